// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the MIPS pipeline stage registers: occupancy width,
// skid FSM state encoding and default control-bundle widths per stage boundary.
package mips_pipe_pkg;

  localparam int OCC_W = 2;

  typedef enum logic [OCC_W-1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL1 = 2'd1,
    ST_FULL2 = 2'd2
  } occState_t;

  // IF/ID carries no control yet; later boundaries shed control as it is consumed
  localparam int CTRL_W_IF_ID  = 1;
  localparam int CTRL_W_ID_EX  = 8;
  localparam int CTRL_W_EX_MEM = 4;
  localparam int CTRL_W_MEM_WB = 2;

endpackage

// File: rtl/pipe_entry_reg.sv
// One pipeline entry: valid + control + data with load/pop/clear.
// Clear kills valid and control; data is zeroed only when CLEAR_DATA is set.
module pipe_entry_reg #(
  parameter int DATA_W     = 32,
  parameter int CTRL_W     = 8,
  parameter int CLEAR_DATA = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              load,
  input  logic              pop,
  input  logic [DATA_W-1:0] inData,
  input  logic [CTRL_W-1:0] inCtrl,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [CTRL_W-1:0] ctrl
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= 1'b0;
      ctrl  <= '0;
      data  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
      ctrl  <= '0;
      if (CLEAR_DATA != 0) data <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= inData;
      ctrl  <= inCtrl;
    end else if (pop) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic MIPS pipeline stage register with valid/ready handshake, stall hold,
// flush-to-bubble and an optional 2-entry skid buffer that registers in_ready.
module pipe_stage_reg
  import mips_pipe_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int CTRL_W     = 8,
  parameter int SKID       = 1,
  parameter int CLEAR_DATA = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              stall,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [OCC_W-1:0]  occupancy
);

  logic              accept, emit;
  logic              mainLoad, mainPop, mainValid;
  logic [DATA_W-1:0] mainSrcData, mainData;
  logic [CTRL_W-1:0] mainSrcCtrl, mainCtrl;

  assign accept = in_valid & in_ready & ~stall & ~flush;
  assign emit   = out_valid & out_ready & ~stall;

  pipe_entry_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CLEAR_DATA(CLEAR_DATA)) mainEntry (
    .clk    (clk),
    .reset  (reset),
    .clear  (flush),
    .load   (mainLoad),
    .pop    (mainPop),
    .inData (mainSrcData),
    .inCtrl (mainSrcCtrl),
    .valid  (mainValid),
    .data   (mainData),
    .ctrl   (mainCtrl)
  );

  generate
    if (SKID != 0) begin : gSkid
      occState_t         state;
      logic              readyReg;
      logic              skidLoad, skidPop, skidValid;
      logic [DATA_W-1:0] skidData;
      logic [CTRL_W-1:0] skidCtrl;

      // FULL2 refills main from the skid entry; otherwise main takes the input
      assign mainLoad    = (state == ST_FULL2) ? emit : (accept & ((state == ST_EMPTY) | emit));
      assign mainPop     = emit & ~mainLoad;
      assign mainSrcData = (state == ST_FULL2) ? skidData : in_data;
      assign mainSrcCtrl = (state == ST_FULL2) ? skidCtrl : in_ctrl;
      assign skidLoad    = accept & (state == ST_FULL1) & ~emit;
      assign skidPop     = emit & (state == ST_FULL2);

      pipe_entry_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CLEAR_DATA(CLEAR_DATA)) skidEntry (
        .clk    (clk),
        .reset  (reset),
        .clear  (flush),
        .load   (skidLoad),
        .pop    (skidPop),
        .inData (in_data),
        .inCtrl (in_ctrl),
        .valid  (skidValid),
        .data   (skidData),
        .ctrl   (skidCtrl)
      );

      // readyReg tracks "next state is not FULL2"; held low for the first cycle after reset
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          state    <= ST_EMPTY;
          readyReg <= 1'b0;
        end else begin
          readyReg <= (state != ST_FULL2);
          if (flush) begin
            state    <= ST_EMPTY;
            readyReg <= 1'b1;
          end else if (!stall) begin
            case (state)
              ST_EMPTY: if (accept) state <= ST_FULL1;
              ST_FULL1: begin
                if (accept & ~emit) begin
                  state    <= ST_FULL2;
                  readyReg <= 1'b0;
                end else if (emit & ~accept) begin
                  state <= ST_EMPTY;
                end
              end
              ST_FULL2: if (emit) begin
                state    <= ST_FULL1;
                readyReg <= 1'b1;
              end
              default: state <= ST_EMPTY;
            endcase
          end
        end
      end

      assign in_ready  = readyReg & ~stall;
      assign occupancy = state;
    end else begin : gSingle
      assign mainLoad    = accept;
      assign mainPop     = emit & ~accept;
      assign mainSrcData = in_data;
      assign mainSrcCtrl = in_ctrl;
      assign in_ready    = ~stall & (~mainValid | out_ready);
      assign occupancy   = {1'b0, mainValid};
    end
  endgenerate

  assign out_valid = mainValid;
  assign out_data  = mainData;
  // A bubble must never assert RegWrite/MemWrite downstream
  assign out_ctrl  = mainValid ? mainCtrl : '0;

  occLegal: assert property (@(posedge clk) disable iff (!reset)
    (occupancy != 2'd3) && ((SKID != 0) || (occupancy != 2'd2)));

endmodule
